// File: rtl/aes_pkg.sv
// Shared AES-128 constants and byte-level helpers for the pipelined encryptor.
package aes_pkg;

   localparam int unsigned NUM_ROUNDS = 10;

   // FIPS-197 S-box, entry 0 in the top byte
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [79:0] RCON = 80'h01_02_04_08_10_20_40_80_1b_36;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b000} +: 8];
   endfunction

   // Rcon for round r, r in 1..NUM_ROUNDS
   function automatic logic [7:0] rcon(input int unsigned r);
      return RCON[7'(8 * (NUM_ROUNDS - r)) +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

// File: rtl/enc_round.sv
// One AES round as a pipeline stage: state, its own round key and valid bit are registered together.
module enc_round
   import aes_pkg::*;
#(
   parameter int unsigned ROUND = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] state_i,
   input  logic [127:0] rk_i,
   input  logic         valid_i,
   output logic [127:0] state_o,
   output logic [127:0] rk_o,
   output logic         valid_o
);

   localparam logic [7:0] RC = rcon(ROUND);
   localparam bit LAST = (ROUND == NUM_ROUNDS);

   logic [127:0] sb, sr, mc;
   logic [31:0]  temp, w0, w1, w2, w3;
   logic [127:0] state_d, state_q, rk_d, rk_q;
   logic         valid_d, valid_q;

   for (genvar i = 0; i < 16; i++) begin : g_sub
      assign sb[127-8*i -: 8] = sbox(state_i[127-8*i -: 8]);
   end

   // row r of column c takes row r of column (c+r) mod 4
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
      assign mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
   end

   // next round key derived from the key this stage received
   assign temp = sub_word({rk_i[23:0], rk_i[31:24]}) ^ {RC, 24'h000000};
   assign w0   = rk_i[127:96] ^ temp;
   assign w1   = rk_i[95:64]  ^ w0;
   assign w2   = rk_i[63:32]  ^ w1;
   assign w3   = rk_i[31:0]   ^ w2;

   always_comb begin
      rk_d    = {w0, w1, w2, w3};
      state_d = (LAST ? sr : mc) ^ rk_d;
      valid_d = valid_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= '0;
         rk_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rk_q    <= rk_d;
         valid_q <= valid_d;
      end
   end

   assign state_o = state_q;
   assign rk_o    = rk_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/enc.sv
// AES-128 encryptor, one block per clock: input whitening register followed by ten round stages.
module enc
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic [127:0] key,
   input  logic [127:0] plaintext,
   output logic [127:0] ciphertext,
   output logic         valid_out
);

   logic [127:0] key_d, key_q, eff_key;
   logic         loaded_d, loaded_q;
   logic [127:0] st0_d, st0_q, rk0_d, rk0_q;
   logic         v0_d, v0_q;

   logic [127:0] st [NUM_ROUNDS+1];
   logic [127:0] rk [NUM_ROUNDS+1];
   logic         vl [NUM_ROUNDS+1];

   // a key presented with enable applies to the block sampled on the same edge
   always_comb begin
      eff_key  = enable ? key : key_q;
      key_d    = eff_key;
      loaded_d = loaded_q | enable;
      st0_d    = plaintext ^ eff_key;
      rk0_d    = eff_key;
      v0_d     = loaded_q | enable;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_q    <= '0;
         loaded_q <= 1'b0;
         st0_q    <= '0;
         rk0_q    <= '0;
         v0_q     <= 1'b0;
      end else begin
         key_q    <= key_d;
         loaded_q <= loaded_d;
         st0_q    <= st0_d;
         rk0_q    <= rk0_d;
         v0_q     <= v0_d;
      end
   end

   assign st[0] = st0_q;
   assign rk[0] = rk0_q;
   assign vl[0] = v0_q;

   for (genvar r = 1; r <= NUM_ROUNDS; r++) begin : g_round
      enc_round #(
         .ROUND(r)
      ) u_round (
         .clk    (clk),
         .rst    (rst),
         .state_i(st[r-1]),
         .rk_i   (rk[r-1]),
         .valid_i(vl[r-1]),
         .state_o(st[r]),
         .rk_o   (rk[r]),
         .valid_o(vl[r])
      );
   end

   assign ciphertext = st[NUM_ROUNDS];
   assign valid_out  = vl[NUM_ROUNDS];

endmodule

// File: tb/tb_enc.sv
// Scoreboard bench for enc: stimulus queues expected blocks, a monitor checks every output cycle.
module tb_enc;

   localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K0  = 128'h0;
   localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [127:0] PT3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
   localparam logic [127:0] PT4 = 128'hf69f2445df4f9b17ad2b417be66c3710;
   localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] PTC = 128'h00112233445566778899aabbccddeeff;

   logic         clk;
   logic         rst;
   logic         enable;
   logic [127:0] key;
   logic [127:0] plaintext;
   logic [127:0] ciphertext;
   logic         valid_out;

   typedef struct {
      logic [127:0] ct;
      bit           chk;
      int           due;
      string        name;
   } exp_t;

   exp_t         q[$];
   exp_t         mon_e;
   int           cyc = 0;
   int           checks = 0;
   int           failures = 0;
   logic [127:0] key_m;
   bit           loaded_m;

   enc dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .key       (key),
      .plaintext (plaintext),
      .ciphertext(ciphertext),
      .valid_out (valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // known-answer table; pairs outside it are expected valid but not value-checked
   function automatic void lookup(input logic [127:0] k, input logic [127:0] p,
                                  output logic [127:0] c, output bit found);
      found = 1'b1;
      c     = '0;
      case ({k, p})
         {K1, PT1}: c = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
         {K1, PT2}: c = 128'hf5d3d58503b9699de785895a96fdbaaf;
         {K1, PT3}: c = 128'h43b1cd7f598ece23881b00e3ed030688;
         {K1, PT4}: c = 128'h7b0c785e27e8ad3f8223207104725dd4;
         {K1, PTB}: c = 128'h3925841d02dc09fbdc118597196a0b32;
         {K0, K0}:  c = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
         {KC, PTC}: c = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
         default:   found = 1'b0;
      endcase
   endfunction

   task automatic drive(input logic en, input logic [127:0] k, input logic [127:0] p,
                        input string name);
      logic [127:0] c;
      bit           f;
      @(negedge clk);
      enable    = en;
      key       = k;
      plaintext = p;
      if (en) begin
         key_m    = k;
         loaded_m = 1'b1;
      end
      if (loaded_m) begin
         lookup(key_m, p, c, f);
         q.push_back('{ct: c, chk: f, due: cyc + 11, name: name});
      end
   endtask

   task automatic pulse_reset(input string name);
      @(negedge clk);
      rst      = 1'b1;
      enable   = 1'b0;
      q.delete();
      loaded_m = 1'b0;
      key_m    = '0;
      #1;
      checks++;
      if (valid_out !== 1'b0 || ciphertext !== '0) begin
         failures++;
         $display("FAIL %s: valid_out=%0b ciphertext=%h, expected valid_out=0 ciphertext=0",
                  name, valid_out, ciphertext);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // monitor: each cycle either the due block is present or valid_out must be low
   always @(posedge clk) begin
      #1;
      if (q.size() != 0 && q[0].due == cyc) begin
         mon_e = q.pop_front();
         checks++;
         if (valid_out !== 1'b1) begin
            failures++;
            $display("FAIL %s: valid_out=%0b at cycle %0d, expected 1", mon_e.name, valid_out, cyc);
         end else if (mon_e.chk && ciphertext !== mon_e.ct) begin
            failures++;
            $display("FAIL %s: ciphertext=%h, expected %h", mon_e.name, ciphertext, mon_e.ct);
         end
      end else begin
         checks++;
         if (valid_out !== 1'b0) begin
            failures++;
            $display("FAIL idle_valid: valid_out=%0b at cycle %0d with no block due, expected 0",
                     valid_out, cyc);
         end
      end
   end

   initial begin
      rst       = 1'b1;
      enable    = 1'b0;
      key       = '0;
      plaintext = '0;
      key_m     = '0;
      loaded_m  = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (valid_out !== 1'b0 || ciphertext !== '0) begin
         failures++;
         $display("FAIL reset_state: valid_out=%0b ciphertext=%h, expected 0 and 0",
                  valid_out, ciphertext);
      end
      rst = 1'b0;

      // no key ever loaded: toggling plaintext must never produce valid output
      for (int i = 0; i < 20; i++)
         drive(1'b0, {$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom}, "no_key");
      repeat (12) @(negedge clk);

      // key load then a stream with enable low and junk on the key input
      drive(1'b1, K1, PT1, "k1_pt1_load");
      drive(1'b0, K0, PT2, "k1_pt2_held");
      drive(1'b0, {$urandom, $urandom, $urandom, $urandom}, PT3, "k1_pt3_held");
      drive(1'b0, KC, PT4, "k1_pt4_held");
      drive(1'b0, K0, PTB, "k1_fips_b");

      // key changes on consecutive cycles
      drive(1'b1, K0, K0, "k0_zero");
      drive(1'b1, K1, PT4, "k1_pt4_switch");
      drive(1'b1, KC, PTC, "kc_fips_c");
      drive(1'b1, K1, PT1, "k1_pt1_switch");
      drive(1'b0, K0, PTB, "k1_fips_b_after");
      for (int i = 0; i < 12; i++) drive(1'b0, K0, PT2, "k1_stream");

      // block in flight when reset hits must vanish
      drive(1'b0, K0, PT3, "doomed_block");
      for (int i = 0; i < 4; i++) drive(1'b0, K0, PT2, "pre_reset_stream");
      pulse_reset("reset_midstream");
      for (int i = 0; i < 15; i++) drive(1'b0, K1, PT1, "after_reset_no_key");

      drive(1'b1, K1, PT1, "reload_k1_pt1");
      for (int i = 0; i < 12; i++) drive(1'b0, K0, PT3, "reload_stream");

      checks++;
      if (q.size() != 0 && q[0].due <= cyc) begin
         failures++;
         $display("FAIL drain: %0d blocks pending with front due %0d at cycle %0d, expected none overdue",
                  q.size(), q[0].due, cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
